// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-stage sequencer.
// Holds the sequencer state enum and counter/address width defaults.
package fetch_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        MISS,
        REDIR
    } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc = 1, sticks at all-ones.
// Ports: clk, rst (async active-low), inc, cnt[CNT_W].
module sat_counter
    import fetch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC enable/select, IF/ID and ID/EX controls.
// Ports: clk, rst, load_stall, branch_*, imem_ready -> imem_req, pc_*, if_id_*, id_ex_flush, counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic             pc_en,
    output logic             pc_src,
    output logic [WIDTH-1:0] pc_target,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic [WIDTH-1:0] held_q;
    logic [WIDTH-1:0] held_d;
    logic             stall_inc;
    logic             redir_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        imem_req    = 1'b0;
        pc_en       = 1'b0;
        pc_src      = 1'b0;
        pc_target   = held_q;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_d     = state_q;
        held_d      = held_q;

        unique case (state_q)
            BOOT: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_d     = RUN;
            end

            RUN: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_src      = 1'b1;
                    pc_target   = branch_target;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (imem_ready) begin
                        pc_en = 1'b1;
                    end else begin
                        // fetch still in flight: park the target
                        held_d  = branch_target;
                        state_d = REDIR;
                    end
                end else if (load_stall) begin
                    id_ex_flush = 1'b1;
                end else if (imem_ready) begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                end else begin
                    if_id_flush = 1'b1;
                    state_d     = MISS;
                end
            end

            MISS: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    held_d      = branch_target;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = REDIR;
                end else begin
                    if (imem_ready) begin
                        state_d = RUN;
                    end
                    if (load_stall) begin
                        // hold IF/ID rather than bubble it
                        id_ex_flush = 1'b1;
                    end else if (imem_ready) begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                    end else begin
                        if_id_flush = 1'b1;
                    end
                end
            end

            REDIR: begin
                imem_req    = 1'b1;
                if_id_flush = 1'b1;
                if (branch_taken) begin
                    // newest redirect replaces the parked one
                    held_d      = branch_target;
                    id_ex_flush = 1'b1;
                end else if (imem_ready) begin
                    pc_en   = 1'b1;
                    pc_src  = 1'b1;
                    state_d = RUN;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign stall_inc = !pc_en && (state_q != BOOT);
    assign redir_inc = pc_en && pc_src;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redir_inc),
        .cnt (redirect_cnt)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl against a flag-based fetch model.
// Drives inputs on the falling edge, samples #1 later / #1 after rising edge.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        load_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_ready;
    logic        imem_req;
    logic        pc_en;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [15:0] stall_cnt;
    logic [15:0] redirect_cnt;
    logic [31:0] pc;

    int n_cmp;
    int n_bad;

    // model: boot pending, waiting on memory, redirect parked + target
    logic        m_boot;
    logic        m_wait;
    logic        m_pend;
    logic [31:0] m_tgt;
    logic [15:0] m_stall;
    logic [15:0] m_redir;
    logic [31:0] m_pc;

    localparam logic [37:0] RST_OUT = {6'b000011, 32'h0};

    fetch_ctrl #(.WIDTH(32), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_stall    (load_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .pc_en         (pc_en),
        .pc_src        (pc_src),
        .pc_target     (pc_target),
        .if_id_en      (if_id_en),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .stall_cnt     (stall_cnt),
        .redirect_cnt  (redirect_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // the PC register this block steers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= '0;
        else if (pc_en) pc <= pc_src ? pc_target : pc + 32'd4;
    end

    function automatic logic [37:0] obs_out();
        return {imem_req, pc_en, pc_src & pc_en, if_id_en,
                if_id_flush, id_ex_flush, pc_target};
    endfunction

    task automatic model_reset();
        m_boot  = 1'b1;
        m_wait  = 1'b0;
        m_pend  = 1'b0;
        m_tgt   = '0;
        m_stall = '0;
        m_redir = '0;
        m_pc    = '0;
    endtask

    // one clock: apply inputs, predict outputs, advance the model
    task automatic cycle(input logic ls, input logic bt,
                         input logic [31:0] tg, input logic rdy,
                         output logic [37:0] oo, output logic [37:0] eo,
                         output logic [63:0] oc, output logic [63:0] ec);
        logic req, en, src, ie, ifl, efl;
        logic [31:0] t, ntg;
        logic nw, np;
        load_stall    = ls;
        branch_taken  = bt;
        branch_target = tg;
        imem_ready    = rdy;
        #1;
        req = 1'b1; en = 1'b0; src = 1'b0;
        ie = 1'b0; ifl = 1'b0; efl = 1'b0;
        t = m_tgt; ntg = m_tgt; nw = m_wait; np = m_pend;
        if (m_boot) begin
            req = 1'b0; ifl = 1'b1; efl = 1'b1;
        end else if (m_pend) begin
            ifl = 1'b1;
            if (bt) begin
                ntg = tg; efl = 1'b1;
            end else if (rdy) begin
                en = 1'b1; src = 1'b1; np = 1'b0;
            end
        end else if (m_wait) begin
            if (bt) begin
                ifl = 1'b1; efl = 1'b1; ntg = tg; np = 1'b1; nw = 1'b0;
            end else begin
                if (rdy) nw = 1'b0;
                if (ls) efl = 1'b1;
                else if (rdy) begin en = 1'b1; ie = 1'b1; end
                else ifl = 1'b1;
            end
        end else begin
            if (bt) begin
                ifl = 1'b1; efl = 1'b1; src = 1'b1; t = tg;
                if (rdy) en = 1'b1;
                else begin ntg = tg; np = 1'b1; end
            end else if (ls) efl = 1'b1;
            else if (rdy) begin en = 1'b1; ie = 1'b1; end
            else begin ifl = 1'b1; nw = 1'b1; end
        end
        eo = {req, en, src & en, ie, ifl, efl, t};
        oo = obs_out();
        if (en) m_pc = src ? t : m_pc + 32'd4;
        if (!m_boot && !en && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (en && src && m_redir != 16'hFFFF) m_redir = m_redir + 16'd1;
        m_boot = 1'b0; m_wait = nw; m_pend = np; m_tgt = ntg;
        @(posedge clk);
        #1;
        oc = {stall_cnt, redirect_cnt, pc};
        ec = {m_stall, m_redir, m_pc};
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            load_stall    = 1'($urandom);
            branch_taken  = 1'($urandom);
            branch_target = $urandom;
            imem_ready    = 1'($urandom);
            #1;
            if (obs_out() !== RST_OUT) begin
                n_bad++;
                $display("FAIL reset_out c%0d got %h want %h", i, obs_out(), RST_OUT);
            end
            n_cmp++;
            if ({stall_cnt, redirect_cnt, pc} !== 64'h0) begin
                n_bad++;
                $display("FAIL reset_cnt c%0d got %h want 0", i,
                         {stall_cnt, redirect_cnt, pc});
            end
            n_cmp++;
            @(negedge clk);
        end
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_boot_run();
        logic [37:0] oo, eo;
        logic [63:0] oc, ec;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, oo, eo, oc, ec);
            if (oo !== eo) begin
                n_bad++;
                $display("FAIL boot_out c%0d got %h want %h", i, oo, eo);
            end
            n_cmp++;
            if (oc[31:0] !== ((i == 0) ? 32'h0 : 32'(i * 4))) begin
                n_bad++;
                $display("FAIL boot_pc c%0d got %h want %h", i, oc[31:0],
                         (i == 0) ? 32'h0 : 32'(i * 4));
            end
            n_cmp++;
        end
    endtask

    task automatic test_load_stall();
        logic [37:0] oo, eo;
        logic [63:0] oc, ec;
        logic [15:0] s0;
        s0 = stall_cnt;
        for (int i = 0; i < 3; i++) begin
            cycle(i < 2, 1'b0, 32'h0, 1'b1, oo, eo, oc, ec);
            if (oo !== eo || oc !== ec) begin
                n_bad++;
                $display("FAIL stall c%0d got %h/%h want %h/%h", i, oo, oc, eo, ec);
            end
            n_cmp++;
        end
        if (stall_cnt - s0 !== 16'd2) begin
            n_bad++;
            $display("FAIL stall_delta got %0d want 2", stall_cnt - s0);
        end
        n_cmp++;
    endtask

    task automatic test_branch_ready();
        logic [37:0] oo, eo;
        logic [63:0] oc, ec;
        logic [15:0] r0;
        r0 = redirect_cnt;
        cycle(1'b0, 1'b1, 32'h100, 1'b1, oo, eo, oc, ec);
        if (oo !== eo || oo !== {6'b111011, 32'h100}) begin
            n_bad++;
            $display("FAIL br_out got %h want %h", oo, {6'b111011, 32'h100});
        end
        n_cmp++;
        if (oc[31:0] !== 32'h100 || redirect_cnt - r0 !== 16'd1) begin
            n_bad++;
            $display("FAIL br_pc got pc %h dcnt %0d want 100 1", oc[31:0],
                     redirect_cnt - r0);
        end
        n_cmp++;
    endtask

    task automatic test_miss_redirect();
        logic [37:0] oo, eo;
        logic [63:0] oc, ec;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, i == 1, 32'h200, i == 3, oo, eo, oc, ec);
            if (oo !== eo || oc !== ec) begin
                n_bad++;
                $display("FAIL miss c%0d got %h/%h want %h/%h", i, oo, oc, eo, ec);
            end
            n_cmp++;
            if (oo[36] !== (i == 3)) begin
                n_bad++;
                $display("FAIL miss_en c%0d got %b want %b", i, oo[36], i == 3);
            end
            n_cmp++;
        end
        if (oo[31:0] !== 32'h200 || oc[31:0] !== 32'h200) begin
            n_bad++;
            $display("FAIL miss_tgt got %h pc %h want 200", oo[31:0], oc[31:0]);
        end
        n_cmp++;
    endtask

    task automatic test_branch_vs_stall();
        logic [37:0] oo, eo;
        logic [63:0] oc, ec;
        cycle(1'b1, 1'b1, 32'h340, 1'b1, oo, eo, oc, ec);
        if (oo !== eo || oo[36:35] !== 2'b11) begin
            n_bad++;
            $display("FAIL br_vs_ls got %h want %h", oo, eo);
        end
        n_cmp++;
    endtask

    task automatic test_random();
        logic [37:0] oo, eo;
        logic [63:0] oc, ec;
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 99) < 65,
                  oo, eo, oc, ec);
            if (oo !== eo) begin
                n_bad++;
                $display("FAIL rand_out c%0d got %h want %h", i, oo, eo);
            end
            n_cmp++;
            if (oc !== ec) begin
                n_bad++;
                $display("FAIL rand_cnt c%0d got %h want %h", i, oc, ec);
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset_redir();
        logic [37:0] oo, eo;
        logic [63:0] oc, ec;
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b1, oo, eo, oc, ec);
        cycle(1'b0, 1'b1, 32'h300, 1'b0, oo, eo, oc, ec);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, oo, eo, oc, ec);
        if (oo !== eo || oo[31:0] !== 32'h300) begin
            n_bad++;
            $display("FAIL rr_redir got %h want %h", oo, eo);
        end
        n_cmp++;
        #2;
        rst = 1'b0;
        #1;
        if (obs_out() !== RST_OUT || {stall_cnt, redirect_cnt, pc} !== 64'h0) begin
            n_bad++;
            $display("FAIL rr_async got %h want %h", obs_out(), RST_OUT);
        end
        n_cmp++;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, oo, eo, oc, ec);
            if (oo !== eo || oc !== ec) begin
                n_bad++;
                $display("FAIL rr_restart c%0d got %h/%h want %h/%h",
                         i, oo, oc, eo, ec);
            end
            n_cmp++;
        end
        if (oc[31:0] !== 32'h8) begin
            n_bad++;
            $display("FAIL rr_pc got %h want 8", oc[31:0]);
        end
        n_cmp++;
    endtask

    task automatic test_saturate();
        do_reset();
        load_stall   = 1'b0;
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        if (stall_cnt !== 16'hFFFF || redirect_cnt !== 16'h0) begin
            n_bad++;
            $display("FAIL saturate got %h/%h want ffff/0", stall_cnt, redirect_cnt);
        end
        n_cmp++;
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst           = 1'b0;
        load_stall    = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        imem_ready    = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_boot_run();
        test_load_stall();
        test_branch_ready();
        test_miss_redirect();
        test_branch_vs_stall();
        test_random();
        test_reset_redir();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
